// File: rtl/fre_calc_pkg.sv
// Shared measurement package: reference clock default, calculator state
// encoding and the 64->32 bit saturation helper.
package fre_calc_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 32'd100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } fc_state_e;

  function automatic logic [31:0] sat_u64_to_u32(input logic [63:0] v);
    logic [31:0] r;
    if (v[63:32] != 32'd0) begin
      r = 32'hFFFF_FFFF;
    end else begin
      r = v[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fre_calc_if.sv
// Gate-stage to frequency-calculator bundle: counts and gate in, result out.
interface fre_calc_if;
  logic [31:0] M;
  logic [31:0] N;
  logic        gate;
  logic [31:0] freq;
  logic        valid;
  logic        busy;
  logic        err;

  modport master (output M, N, gate, input freq, valid, busy, err);
  modport slave  (input M, N, gate, output freq, valid, busy, err);
endinterface

// File: rtl/fre_calc_div.sv
// Restoring divider, 64-bit dividend by 32-bit divisor, one quotient bit per
// clock; done and the final quotient/remainder are presented during the last step.
module div_u64_u32
  import fre_calc_pkg::*;
(
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [63:0] quotient,
  output logic [31:0] remainder
);

  logic [63:0] q_r;
  logic [31:0] rem_r;
  logic [31:0] div_r;
  logic [5:0]  cnt_r;
  logic        run_r;

  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;
  logic        ge_s;
  logic [31:0] rem_nxt_s;
  logic [63:0] q_nxt_s;

  // One restoring step: a clear borrow bit in the 33-bit difference means subtract.
  always_comb begin
    rem_sh_s = {rem_r, q_r[63]};
    diff_s   = rem_sh_s - {1'b0, div_r};
    ge_s     = ~diff_s[32];
    if (ge_s) begin
      rem_nxt_s = diff_s[31:0];
    end else begin
      rem_nxt_s = rem_sh_s[31:0];
    end
    q_nxt_s = {q_r[62:0], ge_s};
  end

  assign done      = run_r & (cnt_r == 6'd63);
  assign quotient  = q_nxt_s;
  assign remainder = rem_nxt_s;

  // Iteration registers: load on start, then 64 shift/subtract steps.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= 64'd0;
      rem_r <= 32'd0;
      div_r <= 32'd0;
      cnt_r <= 6'd0;
      run_r <= 1'b0;
    end else if (start) begin
      q_r   <= dividend;
      rem_r <= 32'd0;
      div_r <= divisor;
      cnt_r <= 6'd0;
      run_r <= 1'b1;
    end else if (run_r) begin
      q_r   <= q_nxt_s;
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r + 6'd1;
      if (done) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fre_calc.sv
// Frequency calculator: on gate fall computes N*CLK_FREQ/M (optionally
// rounded), saturates to 32 bits, and pulses valid with a fixed latency.
module fre_calc
  import fre_calc_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT,
  parameter int unsigned ROUND    = 32'd1
) (
  input logic       clk_100M,
  input logic       rst_n,
  fre_calc_if.slave bus
);

  fc_state_e   state_r;
  fc_state_e   state_nxt_s;
  logic        gate_pre_r;
  logic [31:0] m_r;
  logic [31:0] n_r;
  logic [31:0] freq_r;
  logic        valid_r;
  logic        busy_r;
  logic        err_r;

  logic        trigger_s;
  logic        latch_s;
  logic        start_s;
  logic        fin_zero_s;
  logic        fin_div_s;
  logic [63:0] num_s;
  logic [63:0] div_quot_s;
  logic [31:0] div_rem_unused_s;
  logic        div_done_s;

  assign trigger_s = gate_pre_r & ~bus.gate;

  // Adding M/2 before dividing turns truncation into round-to-nearest.
  assign num_s = (64'(n_r) * 64'(CLK_FREQ))
               + ((ROUND != 32'd0) ? 64'({1'b0, m_r[31:1]}) : 64'd0);

  div_u64_u32 u_div (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .start     (start_s),
    .dividend  (num_s),
    .divisor   (m_r),
    .done      (div_done_s),
    .quotient  (div_quot_s),
    .remainder (div_rem_unused_s)
  );

  // Next-state and one-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    start_s     = 1'b0;
    fin_zero_s  = 1'b0;
    fin_div_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trigger_s) begin
          state_nxt_s = ST_LOAD;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (m_r == 32'd0) begin
          state_nxt_s = ST_DONE;
          fin_zero_s  = 1'b1;
        end else begin
          state_nxt_s = ST_DIV;
          start_s     = 1'b1;
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          state_nxt_s = ST_DONE;
          fin_div_s   = 1'b1;
        end else begin
          state_nxt_s = ST_DIV;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Edge detect, operand latch and registered results (outputs land as DONE is entered).
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      gate_pre_r <= 1'b0;
      m_r        <= 32'd0;
      n_r        <= 32'd0;
      freq_r     <= 32'd0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      gate_pre_r <= bus.gate;
      valid_r    <= fin_zero_s | fin_div_s;
      if (latch_s) begin
        m_r    <= bus.M;
        n_r    <= bus.N;
        busy_r <= 1'b1;
      end
      if (fin_zero_s) begin
        freq_r <= 32'd0;
        err_r  <= 1'b1;
        busy_r <= 1'b0;
      end else if (fin_div_s) begin
        freq_r <= sat_u64_to_u32(div_quot_s);
        err_r  <= 1'b0;
        busy_r <= 1'b0;
      end
    end
  end

  assign bus.freq  = freq_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_fre_calc.sv
// Bench for fre_calc: two instances (rounding on/off) driven together and
// compared every cycle against an arithmetic reference model.
module tb_fre_calc;

  localparam logic [63:0] CLK_F = 64'd100_000_000;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic [31:0] tb_m     = 32'd0;
  logic [31:0] tb_n     = 32'd0;
  logic        tb_gate  = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_100M = ~clk_100M;

  fre_calc_if bus1 ();
  fre_calc_if bus0 ();

  assign bus1.M    = tb_m;
  assign bus1.N    = tb_n;
  assign bus1.gate = tb_gate;
  assign bus0.M    = tb_m;
  assign bus0.N    = tb_n;
  assign bus0.gate = tb_gate;

  fre_calc #(.ROUND(1)) dut1 (.clk_100M(clk_100M), .rst_n(rst_n), .bus(bus1));
  fre_calc #(.ROUND(0)) dut0 (.clk_100M(clk_100M), .rst_n(rst_n), .bus(bus0));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_freq(input logic [31:0] m, input logic [31:0] n, input bit rnd);
    logic [63:0] num;
    logic [63:0] q;
    num = 64'(n) * CLK_F + (rnd ? 64'(m / 32'd2) : 64'd0);
    q   = num / 64'(m);
    if (q > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  // Reference model: a result is due a fixed number of edges after an accepted trigger.
  int          m_cnt   = 0;
  bit          m_valid = 1'b0;
  bit          m_gprev = 1'b0;
  logic [31:0] m_freq1 = 32'd0;
  logic [31:0] m_freq0 = 32'd0;
  bit          m_err   = 1'b0;
  logic [31:0] p_f1, p_f0;
  bit          p_err;

  initial begin
    bit accept;
    forever begin
      @(posedge clk_100M or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_valid = 1'b0; m_gprev = 1'b0;
        m_freq1 = 32'd0; m_freq0 = 32'd0; m_err = 1'b0;
      end else begin
        accept  = (m_cnt == 0) && !m_valid && m_gprev && !tb_gate;
        m_valid = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_valid = 1'b1;
            m_freq1 = p_f1;
            m_freq0 = p_f0;
            m_err   = p_err;
          end
        end
        if (accept) begin
          if (tb_m == 32'd0) begin
            p_f1 = 32'd0; p_f0 = 32'd0; p_err = 1'b1; m_cnt = 1;
          end else begin
            p_f1 = ref_freq(tb_m, tb_n, 1'b1);
            p_f0 = ref_freq(tb_m, tb_n, 1'b0);
            p_err = 1'b0; m_cnt = 65;
          end
        end
        m_gprev = tb_gate;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk_100M);
      chk("valid_r1", 64'(bus1.valid), 64'(m_valid));
      chk("valid_r0", 64'(bus0.valid), 64'(m_valid));
      chk("busy_r1",  64'(bus1.busy),  64'(m_cnt > 0));
      chk("busy_r0",  64'(bus0.busy),  64'(m_cnt > 0));
      chk("freq_r1",  64'(bus1.freq),  64'(m_freq1));
      chk("freq_r0",  64'(bus0.freq),  64'(m_freq0));
      chk("err_r1",   64'(bus1.err),   64'(m_err));
      chk("err_r0",   64'(bus0.err),   64'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  task automatic run(input string name, input logic [31:0] m, input logic [31:0] n,
                     input int exp_lat, input logic [31:0] f1, input logic [31:0] f0, input bit e);
    int lat;
    tb_gate = 1'b1; tb_m = m; tb_n = n;
    cyc(3);
    tb_gate = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(negedge clk_100M);
      if (bus1.valid === 1'b1) break;
      lat++;
    end
    chk({name, "_lat"},   64'(lat),       64'(exp_lat));
    chk({name, "_freq1"}, 64'(bus1.freq), 64'(f1));
    chk({name, "_freq0"}, 64'(bus0.freq), 64'(f0));
    chk({name, "_err"},   64'(bus1.err),  64'(e));
    cyc(1);
  endtask

  initial begin
    int v;
    int r;
    cyc(3);
    chk("rst_freq",  64'(bus1.freq),  64'd0);
    chk("rst_valid", 64'(bus1.valid), 64'd0);
    chk("rst_busy",  64'(bus1.busy),  64'd0);
    chk("rst_err",   64'(bus1.err),   64'd0);
    rst_n = 1'b1;
    cyc(3);

    run("basic", 32'd100_000_000, 32'd1_000, 66, 32'd1_000, 32'd1_000, 1'b0);
    run("round", 32'd100_000_003, 32'd1_000_000, 66, 32'd1_000_000, 32'd999_999, 1'b0);
    run("mzero", 32'd0, 32'd5, 2, 32'd0, 32'd0, 1'b1);
    run("after0", 32'd100_000_000, 32'd7, 66, 32'd7, 32'd7, 1'b0);

    // Second gate fall while busy must be ignored.
    tb_m = 32'd50_000_000; tb_n = 32'd123; tb_gate = 1'b1;
    cyc(3);
    tb_gate = 1'b0;
    cyc(10);
    tb_gate = 1'b1; tb_m = 32'd100_000_000; tb_n = 32'd999;
    cyc(20);
    tb_gate = 1'b0;
    v = 0;
    repeat (60) begin
      @(negedge clk_100M);
      if (bus1.valid === 1'b1) v++;
    end
    chk("ignore_pulses", 64'(v), 64'd1);
    chk("ignore_freq1", 64'(bus1.freq), 64'd246);
    chk("ignore_freq0", 64'(bus0.freq), 64'd246);
    cyc(2);

    // Reset in the middle of a calculation.
    tb_m = 32'd100_000_000; tb_n = 32'd1_000; tb_gate = 1'b1;
    cyc(3);
    tb_gate = 1'b0;
    cyc(40);
    rst_n = 1'b0;
    #1;
    chk("midrst_freq",  64'(bus1.freq),  64'd0);
    chk("midrst_busy",  64'(bus1.busy),  64'd0);
    chk("midrst_valid", 64'(bus1.valid), 64'd0);
    chk("midrst_err",   64'(bus1.err),   64'd0);
    cyc(1);
    rst_n = 1'b1;
    v = 0;
    repeat (80) begin
      @(negedge clk_100M);
      if (bus1.valid === 1'b1) v++;
    end
    chk("midrst_nopulse", 64'(v), 64'd0);
    run("postrst", 32'd100_000_000, 32'd1_000, 66, 32'd1_000, 32'd1_000, 1'b0);
    run("sat", 32'd1, 32'hFFFF_FFFF, 66, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Random gate activity, operands and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        if (!tb_gate) begin
          case ($urandom_range(0, 3))
            0:       tb_m = 32'd0;
            1:       tb_m = 32'($urandom_range(1, 1000));
            2:       tb_m = 32'($urandom);
            default: tb_m = 32'($urandom_range(110_000_000, 90_000_000));
          endcase
          tb_n = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 100_000));
        end
        tb_gate = ~tb_gate;
      end else if (r == 99 && $urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
    end
    cyc(80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
